// File: rtl/sha256_round_ctrl.sv
// rtl/sha256_round_ctrl.sv - SHA-256 block sequencer: schedule, K ROM, working state, hash chaining
module sha256_round_ctrl #(
    parameter int ROUNDS = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    output logic [5:0]   rnd_idx,
    output logic [31:0]  rnd_k,
    output logic [31:0]  rnd_w,
    output logic [255:0] rnd_state_in,
    input  logic [255:0] rnd_state_out,
    output logic         busy,
    output logic         digest_valid,
    output logic [255:0] digest
);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [5:0] LAST = 6'(ROUNDS - 1);

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    state_t        state, state_nxt;
    logic [5:0]    cnt;
    logic [31:0]   win [0:15];
    logic [255:0]  base_h;
    logic [255:0]  working;
    logic [31:0]   w_new;

    // win[k] always holds W_{t+k}, so the next word needed is W_{t+16}
    assign w_new        = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
    assign rnd_idx      = (state == ROUND) ? cnt : 6'd0;
    assign rnd_k        = K[rnd_idx];
    assign rnd_w        = win[0];
    assign rnd_state_in = working;

    always_comb begin
        state_nxt = state;
        blk_ready = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                blk_ready = 1'b1;
                if (blk_valid) state_nxt = ROUND;
            end
            ROUND: begin
                busy = 1'b1;
                if (cnt == LAST) state_nxt = FINAL;
            end
            FINAL: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 6'd0;
            digest       <= IV;
            digest_valid <= 1'b0;
            base_h       <= IV;
            working      <= IV;
            for (int i = 0; i < 16; i++) win[i] <= 32'd0;
        end else begin
            state        <= state_nxt;
            digest_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (blk_valid) begin
                        base_h  <= blk_first ? IV : digest;
                        working <= blk_first ? IV : digest;
                        cnt     <= 6'd0;
                        for (int i = 0; i < 16; i++) win[i] <= blk_data[511-32*i -: 32];
                    end
                end
                ROUND: begin
                    working <= rnd_state_out;
                    if (cnt != LAST) cnt <= cnt + 6'd1;
                    for (int i = 0; i < 15; i++) win[i] <= win[i+1];
                    win[15] <= w_new;
                end
                FINAL: begin
                    // per-word adds: no carry crosses a 32-bit boundary
                    for (int i = 0; i < 8; i++)
                        digest[i*32 +: 32] <= base_h[i*32 +: 32] + working[i*32 +: 32];
                    digest_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
